// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - ALU control codes, funct fields, op classes and FSM encoding
package alu_ctrl_pkg;

  localparam logic [3:0] CODE_ADD  = 4'd0;
  localparam logic [3:0] CODE_SUB  = 4'd1;
  localparam logic [3:0] CODE_AND  = 4'd2;
  localparam logic [3:0] CODE_OR   = 4'd3;
  localparam logic [3:0] CODE_XOR  = 4'd4;
  localparam logic [3:0] CODE_NOR  = 4'd5;
  localparam logic [3:0] CODE_SLT  = 4'd6;
  localparam logic [3:0] CODE_SLTU = 4'd7;
  localparam logic [3:0] CODE_LUI  = 4'd8;
  localparam logic [3:0] CODE_SLL  = 4'd9;
  localparam logic [3:0] CODE_SRL  = 4'd10;
  localparam logic [3:0] CODE_SRA  = 4'd11;
  localparam logic [3:0] CODE_MULT = 4'd12;
  localparam logic [3:0] CODE_DIV  = 4'd13;
  localparam logic [3:0] CODE_NOP  = 4'd15;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_NOR   = 4'b0101;
  localparam logic [3:0] OP_SLT   = 4'b0110;
  localparam logic [3:0] OP_SLTU  = 4'b0111;
  localparam logic [3:0] OP_LUI   = 4'b1000;
  localparam logic [3:0] OP_SLL   = 4'b1001;
  localparam logic [3:0] OP_SRL   = 4'b1010;
  localparam logic [3:0] OP_SRA   = 4'b1011;
  localparam logic [3:0] OP_RTYPE = 4'b1110;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational alu_op/funct decode; MULT/DIV decode only with ALU_CTRL_MULDIV_EN
module alu_op_decode
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic [OP_W-1:0] alu_op,
  input  logic [5:0]      funct,
  output logic [3:0]      code,
  output logic            multicycle,
  output logic            illegal
);

  logic       op_hi_nz;
  logic [3:0] op_lo;

  assign op_lo = alu_op[3:0];

  if (OP_W < 4) begin : g_op_w_err
    $error("alu_op_decode: OP_W must be at least 4");
  end

  // Wider op fields are only legal when the extra bits are zero.
  if (OP_W > 4) begin : g_op_hi
    assign op_hi_nz = |alu_op[OP_W-1:4];
  end else begin : g_op_no_hi
    assign op_hi_nz = 1'b0;
  end

  always_comb begin
    code       = CODE_NOP;
    multicycle = 1'b0;
    illegal    = 1'b0;
    case (op_lo)
      OP_ADD:  code = CODE_ADD;
      OP_SUB:  code = CODE_SUB;
      OP_AND:  code = CODE_AND;
      OP_OR:   code = CODE_OR;
      OP_XOR:  code = CODE_XOR;
      OP_NOR:  code = CODE_NOR;
      OP_SLT:  code = CODE_SLT;
      OP_SLTU: code = CODE_SLTU;
      OP_LUI:  code = CODE_LUI;
      OP_SLL:  code = CODE_SLL;
      OP_SRL:  code = CODE_SRL;
      OP_SRA:  code = CODE_SRA;
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU: code = CODE_ADD;
          FN_SUB, FN_SUBU: code = CODE_SUB;
          FN_AND:          code = CODE_AND;
          FN_OR:           code = CODE_OR;
          FN_XOR:          code = CODE_XOR;
          FN_NOR:          code = CODE_NOR;
          FN_SLT:          code = CODE_SLT;
          FN_SLTU:         code = CODE_SLTU;
          FN_SLL:          code = CODE_SLL;
          FN_SRL:          code = CODE_SRL;
          FN_SRA:          code = CODE_SRA;
`ifdef ALU_CTRL_MULDIV_EN
          FN_MULT, FN_MULTU: begin
            code       = CODE_MULT;
            multicycle = 1'b1;
          end
          FN_DIV, FN_DIVU: begin
            code       = CODE_DIV;
            multicycle = 1'b1;
          end
`endif
          default:         illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
    if (op_hi_nz) begin
      code       = CODE_NOP;
      multicycle = 1'b0;
      illegal    = 1'b1;
    end
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - registered ALU control decode with handshake; ALU_CTRL_MULDIV_EN adds MULT/DIV countdown
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W       = 4,
  parameter int CTR_W      = 4,
  parameter int MULDIV_LAT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  alu_op,
  input  logic [5:0]       funct,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CTR_W-1:0] alu_ctr,
  output logic             multicycle,
  output logic             illegal,
  output logic             busy
);

  if (CTR_W < 4) begin : g_ctr_w_err
    $error("alu_ctrl_seq: CTR_W must be at least 4");
  end
  if (MULDIV_LAT < 2 || MULDIV_LAT > 255) begin : g_lat_err
    $error("alu_ctrl_seq: MULDIV_LAT must be in 2..255");
  end

  logic [1:0] state_q, state_d;
  logic [3:0] ctr_q, ctr_d;
  logic       mc_q, mc_d;
  logic       ill_q, ill_d;
  logic [3:0] dec_code;
  logic       dec_mc;
  logic       dec_ill;
  logic       accept;

  alu_op_decode #(.OP_W(OP_W)) u_decode (
    .alu_op     (alu_op),
    .funct      (funct),
    .code       (dec_code),
    .multicycle (dec_mc),
    .illegal    (dec_ill)
  );

  // HOLD with out_ready frees the output register in the same cycle, giving 1/cycle throughput.
  assign in_ready   = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
  assign accept     = in_valid && in_ready;
  assign out_valid  = (state_q == ST_HOLD);
  assign alu_ctr    = CTR_W'(ctr_q);
  assign multicycle = mc_q;
  assign illegal    = ill_q;

`ifdef ALU_CTRL_MULDIV_EN
  localparam logic [7:0] LAT_M1 = 8'(MULDIV_LAT - 1);

  logic [7:0] cnt_q, cnt_d;

  assign busy = (state_q == ST_BUSY);
`else
  assign busy = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    mc_d    = mc_q;
    ill_d   = ill_q;
`ifdef ALU_CTRL_MULDIV_EN
    cnt_d   = cnt_q;
`endif
    if (accept) begin
      ctr_d   = dec_code;
      mc_d    = dec_mc;
      ill_d   = dec_ill;
      state_d = ST_HOLD;
`ifdef ALU_CTRL_MULDIV_EN
      if (dec_mc) begin
        state_d = ST_BUSY;
        cnt_d   = LAT_M1;
      end
`endif
    end else if ((state_q == ST_HOLD) && out_ready) begin
      state_d = ST_IDLE;
`ifdef ALU_CTRL_MULDIV_EN
    end else if (state_q == ST_BUSY) begin
      cnt_d = cnt_q - 8'd1;
      if (cnt_q == 8'd1) begin
        state_d = ST_HOLD;
      end
`endif
    end else if (state_q != ST_IDLE && state_q != ST_HOLD) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ctr_q   <= CODE_NOP;
      mc_q    <= 1'b0;
      ill_q   <= 1'b0;
`ifdef ALU_CTRL_MULDIV_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      mc_q    <= mc_d;
      ill_q   <= ill_d;
`ifdef ALU_CTRL_MULDIV_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb/tb_alu_ctrl_seq.sv - directed self-checking bench for alu_ctrl_seq
module tb_alu_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] alu_op;
  logic [5:0] funct;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] alu_ctr;
  logic       multicycle;
  logic       illegal;
  logic       busy;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] op;
    logic [5:0] fn;
    logic [3:0] code;
    logic       ill;
  } vec_t;

  vec_t vecs[9];

  alu_ctrl_seq #(.OP_W(4), .CTR_W(4), .MULDIV_LAT(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op     (alu_op),
    .funct      (funct),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_ctr    (alu_ctr),
    .multicycle (multicycle),
    .illegal    (illegal),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int nbusy;
    int nvalid;

    vecs[0] = '{4'hE, 6'h2A, 4'd6,  1'b0};
    vecs[1] = '{4'hE, 6'h3F, 4'd15, 1'b1};
    vecs[2] = '{4'hC, 6'h00, 4'd15, 1'b1};
    vecs[3] = '{4'hE, 6'h21, 4'd0,  1'b0};
    vecs[4] = '{4'hE, 6'h23, 4'd1,  1'b0};
    vecs[5] = '{4'hE, 6'h00, 4'd9,  1'b0};
    vecs[6] = '{4'hE, 6'h03, 4'd11, 1'b0};
    vecs[7] = '{4'h8, 6'h00, 4'd8,  1'b0};
    vecs[8] = '{4'hF, 6'h20, 4'd15, 1'b1};

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    alu_op    = 4'd0;
    funct     = 6'd0;
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    expect_eq("rst_out_valid", 32'(out_valid), 32'd0);
    expect_eq("rst_alu_ctr", 32'(alu_ctr), 32'd15);
    expect_eq("rst_multicycle", 32'(multicycle), 32'd0);
    expect_eq("rst_illegal", 32'(illegal), 32'd0);
    expect_eq("rst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    expect_eq("idle_in_ready", 32'(in_ready), 32'd1);

    // back-to-back sweep of the direct op classes
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      alu_op = 4'(i);
      tick();
      expect_eq("sweep_valid", 32'(out_valid), 32'd1);
      expect_eq("sweep_ctr", 32'(alu_ctr), 32'(i));
      expect_eq("sweep_illegal", 32'(illegal), 32'd0);
    end
    in_valid = 1'b0;
    tick();
    expect_eq("sweep_drain", 32'(out_valid), 32'd0);

    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      alu_op   = vecs[i].op;
      funct    = vecs[i].fn;
      tick();
      expect_eq("vec_ctr", 32'(alu_ctr), 32'(vecs[i].code));
      expect_eq("vec_illegal", 32'(illegal), 32'(vecs[i].ill));
      expect_eq("vec_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    tick();

    // stall in HOLD with a competing request that must be ignored
    in_valid  = 1'b1;
    alu_op    = 4'd3;
    out_ready = 1'b0;
    tick();
    expect_eq("stall_first", 32'(alu_ctr), 32'd3);
    alu_op = 4'd4;
    for (int k = 0; k < 5; k++) begin
      tick();
      expect_eq("stall_valid", 32'(out_valid), 32'd1);
      expect_eq("stall_ctr", 32'(alu_ctr), 32'd3);
      expect_eq("stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    expect_eq("release_valid", 32'(out_valid), 32'd1);
    expect_eq("release_ctr", 32'(alu_ctr), 32'd4);
    in_valid = 1'b0;
    tick();
    expect_eq("release_drain", 32'(out_valid), 32'd0);

`ifdef ALU_CTRL_MULDIV_EN
    in_valid = 1'b1;
    alu_op   = 4'hE;
    funct    = 6'h18;
    tick();
    in_valid = 1'b0;
    expect_eq("mult_in_ready", 32'(in_ready), 32'd0);
    lat   = 1;
    nbusy = 0;
    while (!out_valid && lat < 20) begin
      if (busy) nbusy++;
      tick();
      lat++;
    end
    expect_eq("mult_latency", 32'(lat), 32'd8);
    expect_eq("mult_busy_cycles", 32'(nbusy), 32'd7);
    expect_eq("mult_ctr", 32'(alu_ctr), 32'd12);
    expect_eq("mult_multicycle", 32'(multicycle), 32'd1);
    expect_eq("mult_busy_done", 32'(busy), 32'd0);
    tick();

    in_valid = 1'b1;
    funct    = 6'h1A;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    expect_eq("div_rst_busy", 32'(busy), 32'd0);
    expect_eq("div_rst_ctr", 32'(alu_ctr), 32'd15);
    expect_eq("div_rst_multicycle", 32'(multicycle), 32'd0);
    expect_eq("div_rst_valid", 32'(out_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    nvalid = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (out_valid) nvalid++;
    end
    expect_eq("div_aborted", 32'(nvalid), 32'd0);
`else
    in_valid = 1'b1;
    alu_op   = 4'hE;
    funct    = 6'h1A;
    tick();
    in_valid = 1'b0;
    expect_eq("nodiv_valid", 32'(out_valid), 32'd1);
    expect_eq("nodiv_ctr", 32'(alu_ctr), 32'd15);
    expect_eq("nodiv_illegal", 32'(illegal), 32'd1);
    expect_eq("nodiv_busy", 32'(busy), 32'd0);
    expect_eq("nodiv_multicycle", 32'(multicycle), 32'd0);
    tick();
`endif

    // reset while holding an unconsumed result
    in_valid  = 1'b1;
    alu_op    = 4'd2;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    expect_eq("hold_pre_rst", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    expect_eq("hold_rst_valid", 32'(out_valid), 32'd0);
    expect_eq("hold_rst_ctr", 32'(alu_ctr), 32'd15);
    tick();
    rst_n = 1'b1;
    tick();
    expect_eq("hold_after_rst", 32'(out_valid), 32'd0);
    expect_eq("hold_after_in_ready", 32'(in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 Parameter OP_W, default 4: width of alu_op.
REQ-002 Parameter CTR_W, default 4: width of alu_ctr.
REQ-003 Parameter MULDIV_LAT, default 8, legal range 2..255: total cycles from accept to out_valid for MULT/DIV ops.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous reset, active low.
REQ-006 in_valid  in  1  request present.
REQ-007 in_ready  out  1  block can accept a request this cycle.
REQ-008 alu_op  in  OP_W  main-decoder ALU operation class.
REQ-009 funct  in  6  instruction funct field; used only when alu_op selects R-type.
REQ-010 out_valid  out  1  alu_ctr/multicycle/illegal are valid.
REQ-011 out_ready  in  1  consumer takes the output this cycle.
REQ-012 alu_ctr  out  CTR_W  decoded ALU control code.
REQ-013 multicycle  out  1  current output is MULT or DIV.
REQ-014 illegal  out  1  current output came from an undefined alu_op/funct.
REQ-015 busy  out  1  multicycle countdown in progress.

Function
REQ-016 A request is accepted when in_valid and in_ready are both high; otherwise inputs are ignored.
REQ-017 alu_op decode: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOR, 0110 SLT, 0111 SLTU, 1000 LUI, 1001 SLL, 1010 SRL, 1011 SRA, 1110 R-type (decode funct), all other values illegal.
REQ-018 funct decode: 0x20/0x21 ADD, 0x22/0x23 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT, 0x2B SLTU, 0x00 SLL, 0x02 SRL, 0x03 SRA, 0x18/0x19 MULT, 0x1A/0x1B DIV, all other values illegal.
REQ-019 Codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, NOR 5, SLT 6, SLTU 7, LUI 8, SLL 9, SRL 10, SRA 11, MULT 12, DIV 13, NOP 15. Illegal requests output NOP with illegal=1.
REQ-020 FSM states: IDLE (output empty), HOLD (output valid, waiting for out_ready), BUSY (multicycle countdown).
REQ-021 Single-cycle op accepted -> HOLD next cycle with out_valid=1; latency 1 cycle.
REQ-022 MULT/DIV accepted -> BUSY with counter loaded to MULDIV_LAT-1 and busy=1; counter decrements each cycle; at count 1 the next state is HOLD, so out_valid rises exactly MULDIV_LAT cycles after accept.
REQ-023 In HOLD, out_ready=1 -> IDLE unless a new request is accepted in the same cycle, which reloads the output (back-to-back throughput of 1 per cycle).
REQ-024 in_ready = (state==IDLE) or (state==HOLD and out_ready); in_ready=0 in BUSY.
REQ-025 Outputs remain stable while out_valid=1 and out_ready=0.
REQ-026 alu_op widths OP_W>4: upper bits nonzero -> illegal. CTR_W<4 is a parameter error.

Reset
REQ-027 rst_n low -> state IDLE, out_valid 0, alu_ctr NOP, multicycle 0, illegal 0, busy 0, counter 0, immediately and asynchronously.
REQ-028 Reset asserted during BUSY or HOLD aborts the operation; no output is produced for it after release.

Configuration
REQ-029 Macro ALU_CTRL_MULDIV_EN defined: MULT/DIV decode and BUSY state as above.
REQ-030 ALU_CTRL_MULDIV_EN undefined: funct 0x18-0x1B decode as illegal, BUSY state and counter omitted, busy tied 0, multicycle tied 0.

Structure
REQ-031 Package alu_ctrl_pkg holds the ALU code constants, funct constants, alu_op class constants and the FSM state encoding.
REQ-032 Combinational decode lives in sub-module alu_op_decode (alu_op, funct -> code, multicycle, illegal); alu_ctrl_seq holds the FSM, counter and output register.

Verification
REQ-033 Sweep alu_op 0000..1011 with out_ready=1 -> alu_ctr 0..11 one cycle after each accept, illegal=0.
REQ-034 alu_op 1110, funct 0x2A -> alu_ctr 6; funct 0x3F -> alu_ctr 15, illegal=1; alu_op 1100 -> illegal=1.
REQ-035 MULDIV enabled, MULDIV_LAT=8, alu_op 1110 funct 0x18 -> busy high 7 cycles, in_ready 0, out_valid rises 8 cycles after accept with alu_ctr 12, multicycle=1.
REQ-036 out_ready held 0 for 5 cycles in HOLD -> outputs stable and in_ready 0; then out_ready 1 with new in_valid -> new result next cycle, no bubble.
REQ-037 rst_n pulsed low 3 cycles after a DIV accept -> all outputs at reset values; no out_valid for the DIV after release.
REQ-038 MULDIV disabled build, funct 0x1A -> alu_ctr 15, illegal=1, latency 1, busy stays 0.
